// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between four requesters and the round-robin grant encoder.
// master = requester side (drives req/done), slave = encoder side (drives grant outputs).
interface rr_grant_encoder_if;
    logic [3:0] req;
    logic       done;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant_valid,
        input  grant_idx,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant_valid,
        output grant_idx,
        output timeout
    );
endinterface

// File: rtl/rr_grant_encoder.sv
// Purpose: round-robin arbiter for 4 requesters, registered 2-bit select for the 2-to-4 decoder.
// Latency: grant visible the cycle after the request edge; release one edge after done/drop/hold limit.
// Backpressure: none; a requester keeps req high until granted, done ends its grant early.
module rr_grant_encoder #(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_encoder_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    logic [1:0] pick;
    logic       any_req;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       release_now;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr_q + 2'(i)]) begin
                pick = ptr_q + 2'(i);
            end
        end
    end

    assign any_req     = |bus.req;
    assign rel_done    = bus.done;
    assign rel_drop    = !bus.req[idx_q];
    assign rel_hold    = (cnt_q == 8'(HOLD_MAX - 1));
    assign release_now = rel_done || rel_drop || rel_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)     state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d = pick;
                    cnt_d = 8'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = idx_q + 2'd1;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d = rel_hold && !rel_done && !rel_drop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.grant_valid = (state_q == GRANT);
    assign bus.grant_idx   = idx_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: directed plan scenarios plus random traffic, scored against
// a cycle-level reference model through an expectation queue drained by a separate monitor.
module tb_rr_grant_encoder;

    localparam int HOLD_MAX = 4;

    typedef struct packed {
        logic       gv;
        logic [1:0] idx;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;
    rr_grant_encoder_if bus ();

    rr_grant_encoder #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the bus, for how many cycles, and where the next scan starts.
    int       m_owner = -1;
    int       m_age   = 0;
    int       m_first = 0;
    logic [1:0] m_idx = 2'd0;
    logic       m_to  = 1'b0;

    task automatic model_step(input logic r, input logic [3:0] q, input logic d);
        bit hit;
        if (!r) begin
            m_owner = -1; m_age = 0; m_first = 0; m_idx = 2'd0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            hit  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_first + k) % 4;
                if (!hit && q[c]) begin
                    hit = 1'b1;
                    m_owner = c;
                    m_idx = 2'(c);
                    m_age = 1;
                end
            end
        end else begin
            m_to = 1'b0;
            if (d || !q[m_owner] || m_age == HOLD_MAX) begin
                m_to    = !d && q[m_owner] && (m_age == HOLD_MAX);
                m_first = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic d);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        bus.req  = q;
        bus.done = d;
        model_step(r, q, d);
        e.gv  = (m_owner >= 0);
        e.idx = m_idx;
        e.to  = m_to;
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input int act, input int req_v);
        n_checks++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req_v);
        end
    endtask

    // Monitor: one expectation per clock edge, compared one step after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check1("grant_valid", int'(bus.grant_valid), int'(e.gv));
                check1("grant_idx",   int'(bus.grant_idx),   int'(e.idx));
                check1("timeout",     int'(bus.timeout),     int'(e.to));
            end
        end
    end

    initial begin
        logic [3:0] rq;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset with all requests high
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b0000, 1'b0);

        // Single request on requester 2, done at the third grant cycle, then ptr=3 check
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b1);

        // Rotation from a fresh reset
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'b1111, 1'b0);
            step(1'b1, 4'b1111, 1'b1);
        end

        // Hold-limit timeout with requester 0 held
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0001, 1'b0);

        // done coincides with the hold limit
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b0);

        // Dropped request and reset mid-grant
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b1);

        // Random traffic: sticky requests, occasional done and rare reset
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 63) != 0), rq, ($urandom_range(0, 5) == 0));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check1("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
